// File: rtl/accum_cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode field width, opcode
// values and FSM state codes (the state code is exported on CheckState).
package accum_cpu_pkg;

  localparam int OPC_W = 4;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_LOAD   = 4'h0;
  localparam opcode_t OP_STORE  = 4'h1;
  localparam opcode_t OP_ADD    = 4'h2;
  localparam opcode_t OP_SUB    = 4'h3;
  localparam opcode_t OP_INPUT  = 4'h4;
  localparam opcode_t OP_OUTPUT = 4'h5;
  localparam opcode_t OP_JZ     = 4'h6;
  localparam opcode_t OP_JPOS   = 4'h7;
  localparam opcode_t OP_JMP    = 4'h8;
  localparam opcode_t OP_AND    = 4'h9;
  localparam opcode_t OP_OR     = 4'hA;
  localparam opcode_t OP_LDI    = 4'hB;
  localparam opcode_t OP_HALT   = 4'hC;
  localparam opcode_t OP_JC     = 4'hD;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_INWAIT = 4'd4,
    ST_HALT   = 4'd5
  } state_t;

endpackage

// File: rtl/accum_cpu_gen2_if.sv
// External program-load port. The loader drives it; the CPU consumes it.
interface accum_cpu_gen2_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;

  modport master (output prog_we, prog_addr, prog_data);
  modport slave  (input  prog_we, prog_addr, prog_data);
endinterface

// File: rtl/accum_cpu_ctrl.sv
// Sequencer for the accumulator CPU: instruction-cycle FSM, Enter edge
// detection and the one-hot step strobes the datapath acts on.
module accum_cpu_ctrl
  import accum_cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    start,
  input  logic    enter,
  input  opcode_t opcode,
  output state_t  state,
  output logic    fetch,
  output logic    decode,
  output logic    exec,
  output logic    capture,
  output logic    restart,
  output logic    load_ok,
  output logic    halt
);

  logic enter_q;
  logic enter_edge;

  // enter_q tracks Enter in every state, so a press already held when
  // INWAIT is entered produces no edge until released and pressed again.
  assign enter_edge = enter && !enter_q;

  assign load_ok = (state == ST_IDLE) || (state == ST_HALT);
  assign restart = load_ok && start;
  assign fetch   = (state == ST_FETCH);
  assign decode  = (state == ST_DECODE);
  assign exec    = (state == ST_EXEC);
  assign capture = (state == ST_INWAIT) && enter_edge;
  assign halt    = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      enter_q <= 1'b0;
    end else begin
      enter_q <= enter;
      case (state)
        ST_IDLE, ST_HALT: if (start) state <= ST_FETCH;
        ST_FETCH:         state <= ST_DECODE;
        ST_DECODE:        state <= ST_EXEC;
        ST_EXEC: begin
          case (opcode)
            OP_INPUT: state <= ST_INWAIT;
            OP_HALT:  state <= ST_HALT;
            default:  state <= ST_FETCH;
          endcase
        end
        ST_INWAIT:        if (enter_edge) state <= ST_FETCH;
        default:          state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/accum_cpu_gen2.sv
// Second-generation accumulator CPU: datapath, registers and the unified
// program/data memory; sequencing comes from accum_cpu_ctrl.
module accum_cpu_gen2
  import accum_cpu_pkg::*;
#(
  parameter int DATA_W = 8,  // must be >= ADDR_W + OPC_W
  parameter int ADDR_W = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Enter,
  input  logic [DATA_W-1:0] data_in,
  accum_cpu_gen2_if.slave   prog,
  output logic [DATA_W-1:0] dataOut,
  output logic              out_valid,
  output logic [3:0]        CheckState,
  output logic [OPC_W-1:0]  IR,
  output logic              IRload,
  output logic              Halt,
  output logic              Carry
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] ir_word;
  logic [DATA_W-1:0] opnd;

  opcode_t           op;
  logic [ADDR_W-1:0] ir_addr;
  state_t            state;
  logic              do_fetch, do_decode, do_exec, do_capture, do_restart, load_ok;
  logic              store;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign op      = ir_word[DATA_W-1 -: OPC_W];
  assign ir_addr = ir_word[ADDR_W-1:0];

  accum_cpu_ctrl u_ctrl (
    .clk     (Clock),
    .rst     (Reset),
    .start   (Start),
    .enter   (Enter),
    .opcode  (op),
    .state   (state),
    .fetch   (do_fetch),
    .decode  (do_decode),
    .exec    (do_exec),
    .capture (do_capture),
    .restart (do_restart),
    .load_ok (load_ok),
    .halt    (Halt)
  );

  assign CheckState = state;
  assign IR         = op;
  assign IRload     = do_fetch;

  // STORE and program loads are mutually exclusive by state, so one port
  // serves both; a reset cycle suppresses any write in flight.
  assign store     = do_exec && (op == OP_STORE);
  assign mem_we    = !Reset && (store || (load_ok && prog.prog_we));
  assign mem_waddr = store ? ir_addr : prog.prog_addr;
  assign mem_wdata = store ? acc : prog.prog_data;

  // NOTE: the memory array has no reset branch on purpose: program contents
  // survive Reset, and a reset loop over the array would not map onto RAM.
  always_ff @(posedge Clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // NOTE: every register here uses <= so all updates see pre-edge values,
  // e.g. the ADD below reads the old acc while writing the new one.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc        <= '0;
      acc       <= '0;
      ir_word   <= '0;
      opnd      <= '0;
      dataOut   <= '0;
      Carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= do_exec && (op == OP_OUTPUT);
      if (do_restart) pc <= '0;
      if (do_fetch) begin
        ir_word <= mem[pc];
        pc      <= pc + 1'b1;
      end
      if (do_decode)  opnd <= mem[ir_addr];
      if (do_capture) acc  <= data_in;
      if (do_exec) begin
        case (op)
          OP_LOAD:   acc <= opnd;
          OP_ADD:    {Carry, acc} <= {1'b0, acc} + {1'b0, opnd};
          OP_SUB: begin
            acc   <= acc - opnd;
            Carry <= (acc >= opnd);
          end
          OP_OUTPUT: dataOut <= acc;
          OP_JZ:     if (acc == '0) pc <= ir_addr;
          OP_JPOS:   if ((acc != '0) && !acc[DATA_W-1]) pc <= ir_addr;
          OP_JMP:    pc <= ir_addr;
          OP_AND:    acc <= acc & opnd;
          OP_OR:     acc <= acc | opnd;
          OP_LDI:    acc <= DATA_W'(ir_addr);
          OP_JC:     if (Carry) pc <= ir_addr;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: doc/accum_cpu_gen2.md
Name: accum_cpu_gen2

Overview:
Parametrised second-generation accumulator microprocessor. Integrates control FSM, accumulator datapath and a unified program/data memory in one block. Extends the 3-bit-opcode machine with:
- configurable data width and memory depth
- 4-bit opcodes, including logic ops, load-immediate, unconditional jump and carry jump
- an external program-load port
- a registered output-valid strobe
Sits at top level, driven by the board's switches and Enter button, with dataOut and status shown on LEDs and 7-segment displays.

Parameters:
DATA_W, 8, accumulator/memory word width; must satisfy DATA_W >= ADDR_W+4
ADDR_W, 4, memory address width; depth = 2**ADDR_W words

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  synchronous active-high reset
Start  input  1  1-cycle pulse; in IDLE or HALT starts execution from PC=0
Enter  input  1  operator handshake for INPUT; rising-edge detected internally
data_in  input  DATA_W  operand for INPUT
prog_we  input  1  program-memory write enable; honoured only in IDLE or HALT
prog_addr  input  ADDR_W  program write address
prog_data  input  DATA_W  program write data
dataOut  output  DATA_W  OUTPUT register
out_valid  output  1  1-cycle pulse, the cycle after dataOut updates
CheckState  output  4  current FSM state code
IR  output  4  opcode field of instruction register
IRload  output  1  high during FETCH
Halt  output  1  high in HALT state
Carry  output  1  carry/no-borrow flag

Behaviour:
Reset:
- state=IDLE; PC=0, A=0, IR=0, dataOut=0, Carry=0, out_valid=0, enter_q=0.
- Memory contents are NOT cleared.
- Reset at any time, including mid-INWAIT or mid-EXEC, aborts the instruction; no memory write occurs that cycle.

Instruction word: opcode = word[DATA_W-1:DATA_W-4]; addr = word[ADDR_W-1:0]; remaining bits ignored.

Memory:
- Combinational read, synchronous write.
- STORE write and prog_we never coincide, because prog_we is ignored outside IDLE/HALT.

Opcodes:
- 0 LOAD: A=M[a]
- 1 STORE: M[a]=A
- 2 ADD: {C,A}=A+M[a]
- 3 SUB: A=A-M[a]; C=1 iff A>=M[a] (unsigned, no borrow)
- 4 INPUT: wait for Enter, A=data_in
- 5 OUTPUT: dataOut=A
- 6 JZ: PC=a if A==0
- 7 JPOS: PC=a if A!=0 and A[DATA_W-1]==0
- 8 JMP: PC=a
- 9 AND: A&=M[a]
- A OR: A|=M[a]
- B LDI: A=zero-extended a
- C HALT
- D JC: PC=a if C
- E, F: NOP
- Carry changes only on ADD and SUB.

FSM states (CheckState code):
- IDLE(0): Start -> FETCH with PC=0.
- FETCH(1): IR<=M[PC]; PC<=PC+1 modulo 2**ADDR_W, wrapping 15->0 at default. IRload=1.
- DECODE(2): latch operand M[addr] into a register.
- EXEC(3): perform the op, then:
  - INPUT -> INWAIT
  - HALT -> HALT
  - otherwise -> FETCH
- INWAIT(4):
  - enter_q <= Enter every cycle; edge = Enter & ~enter_q.
  - On edge: A<=data_in, go to FETCH.
  - Enter already high on entry needs release and re-press.
- HALT(5): Halt=1. Start -> FETCH with PC=0. Accumulator and Carry are retained.

Timing:
- Non-input instructions take exactly 3 cycles.
- out_valid rises the cycle after OUTPUT's EXEC and lasts 1 cycle.
- Start outside IDLE/HALT is ignored.
- Enter edge outside INWAIT is ignored.

Decomposition:
- Shared package accum_cpu_pkg holds:
  - opcode localparams (OP_LOAD..OP_JC)
  - state codes (ST_IDLE..ST_HALT)
  - opcode field width 4
- One sub-module, accum_cpu_ctrl: FSM, Enter edge detect, control strobes.
- Datapath, memory and registers stay in the top.

Test Plan:
- Add and output: load M0=0x40, M1=0x2E, M2=0x50, M3=0xC0, M14=0x05; Start; Enter with data_in=0x03 -> dataOut=0x08, one out_valid pulse, then Halt=1, CheckState=5.
- Countdown loop: LDI 3, SUB one(=1), OUTPUT, JPOS to SUB, HALT -> dataOut sequence 2,1,0, then Halt. No-borrow keeps Carry=1 throughout.
- Carry and JC: A=0xF0 ADD M=0x20 -> A=0x10, Carry=1, JC taken. SUB 0x20 from 0x10 -> A=0xF0, Carry=0, JC not taken.
- Enter edge and reset: Enter held high entering INWAIT -> no capture until release and re-press. Reset asserted in INWAIT -> state=0, A=0, memory intact, program reruns on Start.
- PC wrap and write protection: program with JMP-free code through address 15 -> next fetch from address 0. prog_we pulses while state=FETCH/EXEC -> memory unchanged.
- Parameter sweep: DATA_W=12, ADDR_W=6, with HALT at address 63 reached by JMP 63 -> Halt=1. LDI 0x3F -> A=0x03F.
